yuna_scan_reader: RTL
=====================

Name: yuna_scan_reader

Overview:
- Reader end of the multiplexed display/data interface of the yukiyuna counter block.
- The counter block outputs one 8-bit value per 3-bit select; this block drives the select round-robin and samples each value after a settle window.
- It assembles all 8 positions into a published frame and exposes the frame through a registered read port, a frame strobe and a frame counter.
- Sits between the counter/display core and downstream consumers (status logic, host readout).

Parameters:
- DWELL_CYCLES, 500, clock cycles spent on each select position; legal range is greater than SETTLE_CYCLES and at most 65535.
- SETTLE_CYCLES, 2, cycles after a select change before sampling; must be at least 1.
- DATA_W, 8, width of sampled data.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; synchronous, active-low.
- en  in  1  scan enable.
- sel  out  3  select driven to the source block.
- data_in  in  DATA_W  value returned by the source for the current sel.
- frame_valid  out  1  one-cycle pulse when a new frame is published.
- frame_changed  out  1  valid with frame_valid; 1 if any entry differs from the previous published frame.
- frame_cnt  out  8  count of published frames, wraps 255 to 0.
- rd_addr  in  3  read index into the published frame.
- rd_data  out  DATA_W  published frame entry, registered.

Behaviour:
- Reset (rst=0 at a clk edge): the following all clear to 0 — sel, frame_valid, frame_changed, frame_cnt, rd_data, dwell counter, shadow regs, frame regs. State goes to IDLE.
- State IDLE: sel=0. On en=1 the next state is SCAN with position 0 and dwell counter d=0.
- State SCAN: d increments every cycle from 0 to DWELL_CYCLES-1.
  - At d==SETTLE_CYCLES: shadow[sel] <= data_in.
  - At d==DWELL_CYCLES-1: d<=0 and sel<=sel+1 (7 wraps to 0).
  - If sel==7 at that point, the block publishes.
- Publish:
  - frame regs <= shadow, including the value sampled this scan for position 7.
  - frame_valid=1 for exactly one cycle.
  - frame_cnt+1, modulo 256.
  - frame_changed = (new frame != old frame regs); it is 0 whenever frame_valid=0.
- Frame period is 8*DWELL_CYCLES cycles. The first publish is 8*DWELL_CYCLES cycles after the IDLE->SCAN transition.
- en dropped mid-scan: return to IDLE on the next edge, discard the partial scan (shadow is not published), sel=0. Frame regs and frame_cnt are kept.
- Reset mid-scan: identical to power-on reset. Frame regs and frame_cnt are cleared.
- Read port: rd_data <= frame[rd_addr] every cycle, giving 1-cycle latency. In the publish cycle, rd_data returns the old frame; the new frame is visible from the next cycle.
- sel is registered and glitch-free, changing only at dwell boundaries.

Optional Feature:
- Macro: YUNA_SCAN_CONFIRM_EN.
- Defined:
  - A completed scan is published only if the shadow equals the previous completed scan (kept in an extra confirm register).
  - Otherwise the scan updates the confirm register only, with no frame_valid and no frame_cnt change.
  - The confirm register clears on reset and on en deassert, so the first publish needs two matching scans.
- Undefined: every completed scan is published; the confirm register is not present.

Decomposition:
- Shared package yukiyuna_pkg holds:
  - the NUM_POS=8 constant;
  - the SEL_W=3 constant;
  - the state typedef {ST_IDLE, ST_SCAN};
  - the default DWELL/SETTLE constants, shared with the counter block and testbenches.
- One natural sub-module, yuna_dwell_timer: counts d, raises sample_tick at SETTLE_CYCLES and raises adv_tick at DWELL_CYCLES-1.
- Frame storage and compare logic stay in the top level.

Test Plan:
Parameters for all scenarios: DWELL_CYCLES=8, SETTLE_CYCLES=2. The source model returns data_in = 8'h10+sel.
1. Reset then en=1 -> sel steps through 0..7 every 8 cycles; frame_valid pulses at cycle 64; frame_cnt=1; frame_changed=1; rd_addr=3 gives rd_data=8'h13 one cycle later.
2. Source held constant for 3 frames -> frame_valid at cycles 64/128/192; frame_changed=1,0,0; frame_cnt=3.
3. en=0 at cycle 40 (position 5) -> sel=0 next cycle and no frame_valid. Re-enable at cycle 50 -> the next publish is at cycle 114. The frame regs keep their previous contents meanwhile.
4. Source data_in glitches to 8'hFF at d=1 of position 2 only -> the sampled value for position 2 is 8'h12, because sampling occurs at d=2.
5. 256 frames published -> frame_cnt wraps to 0 on the 256th frame_valid.
6. With YUNA_SCAN_CONFIRM_EN: the source changes position 4 every scan -> no frame_valid. Source then held stable -> frame_valid on the second matching scan.

Source files
------------

// File: rtl/yukiyuna_pkg.sv
// Shared constants and types for the yukiyuna counter block and its scan reader.
package yukiyuna_pkg;

  localparam int NUM_POS        = 8;
  localparam int SEL_W          = 3;
  localparam int CNT_W          = 16;
  localparam int DWELL_DEFAULT  = 500;
  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/yuna_dwell_timer.sv
// Dwell counter for one select position: d runs 0..DWELL_CYCLES-1 while run is high.
module yuna_dwell_timer
  import yukiyuna_pkg::*;
#(
  parameter int DWELL_CYCLES  = DWELL_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sample_tick,
  output logic adv_tick
);

  localparam logic [CNT_W-1:0] SETTLE_D = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_D   = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] d_q, d_d;

  // Dropping run parks the counter at 0 so a restart begins a fresh dwell.
  always_comb begin
    d_d = '0;
    if (run && (d_q != LAST_D)) d_d = d_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) d_q <= '0;
    else      d_q <= d_d;
  end

  assign sample_tick = run && (d_q == SETTLE_D);
  assign adv_tick    = run && (d_q == LAST_D);

endmodule

// File: rtl/yuna_scan_reader.sv
// Round-robin reader of the multiplexed counter outputs; publishes 8-entry frames.
// Optional YUNA_SCAN_CONFIRM_EN: publish only when two consecutive scans agree.
//
// state   | meaning
// ST_IDLE | sel parked at 0, no sampling
// ST_SCAN | stepping sel, sampling each position after the settle window
module yuna_scan_reader
  import yukiyuna_pkg::*;
#(
  parameter int DWELL_CYCLES  = DWELL_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] data_in,
  output logic              frame_valid,
  output logic              frame_changed,
  output logic [7:0]        frame_cnt,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef logic [NUM_POS-1:0][DATA_W-1:0] frame_t;

  scan_state_e       state_q, state_d;
  logic              scan_run, sample_tick, adv_tick, scan_done, publish;
  logic [SEL_W-1:0]  sel_q, sel_d;
  frame_t            shadow_q, shadow_d, frame_q;
  logic              valid_q, changed_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en)  state_d = ST_SCAN;
      ST_SCAN: if (!en) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_run = (state_q == ST_SCAN) && en;
  end

  yuna_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .run        (scan_run),
    .sample_tick(sample_tick),
    .adv_tick   (adv_tick)
  );

  // shadow_d already holds a position-7 sample taken on the same edge as the
  // publish, which matters when SETTLE_CYCLES == DWELL_CYCLES-1.
  always_comb begin
    shadow_d = shadow_q;
    if (sample_tick) shadow_d[sel_q] = data_in;
    scan_done = adv_tick && (sel_q == SEL_W'(NUM_POS - 1));
    sel_d = sel_q;
    if (!scan_run)     sel_d = '0;
    else if (adv_tick) sel_d = sel_q + 1'b1;
  end

`ifdef YUNA_SCAN_CONFIRM_EN
  frame_t confirm_q;
  logic   confirm_vld_q;

  assign publish = scan_done && confirm_vld_q && (shadow_d == confirm_q);

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      confirm_q     <= '0;
      confirm_vld_q <= 1'b0;
    end else if (scan_done) begin
      confirm_q     <= shadow_d;
      confirm_vld_q <= 1'b1;
    end
  end
`else
  assign publish = scan_done;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q     <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
    end else begin
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      valid_q   <= publish;
      changed_q <= publish && (shadow_d != frame_q);
      if (publish) begin
        frame_q <= shadow_d;
        cnt_q   <= cnt_q + 8'd1;
      end
      rd_q <= frame_q[rd_addr];
    end
  end

  assign sel           = sel_q;
  assign frame_valid   = valid_q;
  assign frame_changed = changed_q;
  assign frame_cnt     = cnt_q;
  assign rd_data       = rd_q;

endmodule
